led_scheduler: RTL and testbench

LED_SCHEDULER -- requirements
Module: led_scheduler

---
 rtl/led_scheduler.sv | 137 +++++++++++++
 tb/tb_led_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/led_scheduler.sv
// LED pattern scheduler: a prescaled step generator driving five board LEDs
// through chase, bounce, binary-count and blink patterns.
// Every output comes straight from a flop, so no input reaches an output
// within the same cycle.
module led_scheduler #(
    parameter int WIDTH = 24
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic [1:0] MODE,
    output logic [4:0] LED,
    output logic       TICK,
    output logic       STATE
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [1:0] MODE_CHASE  = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_BINARY = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic [WIDTH-1:0] PRE_LAST = '1;

    state_t           state;
    logic [WIDTH-1:0] pre;
    logic [1:0]       mode_r;
    logic             dir;

    logic             step_edge;
    logic [4:0]       next_led;
    logic             next_dir;

    // Starting LED image for each pattern, used on entry and on a mode switch
    function automatic logic [4:0] initial_pattern(input logic [1:0] m);
        case (m)
            MODE_CHASE:  initial_pattern = 5'b00001;
            MODE_BOUNCE: initial_pattern = 5'b00001;
            MODE_BINARY: initial_pattern = 5'b00000;
            default:     initial_pattern = 5'b11111;
        endcase
    endfunction

    // The prescaler's last count marks the edge on which a pattern step lands
    assign step_edge = (pre == PRE_LAST);

    assign STATE = (state == RUN);

    // Next LED image and bounce direction if the current pattern advances
    always_comb begin
        next_led = LED;
        next_dir = dir;
        case (mode_r)
            MODE_CHASE: begin
                next_led = {LED[3:0], LED[4]};
            end
            MODE_BOUNCE: begin
                if (dir == DIR_UP) begin
                    next_led = {LED[3:0], 1'b0};
                    if (LED[3]) begin
                        next_dir = DIR_DOWN;
                    end
                end else begin
                    next_led = {1'b0, LED[4:1]};
                    if (LED[1]) begin
                        next_dir = DIR_UP;
                    end
                end
            end
            MODE_BINARY: begin
                next_led = LED + 5'd1;
            end
            default: begin
                next_led = ~LED;
            end
        endcase
    end

    // Run/idle control, prescaler, and the registered LED/TICK outputs;
    // reset beats everything, and dropping EN beats a coincident step
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            LED    <= 5'b00000;
            TICK   <= 1'b0;
            pre    <= '0;
            mode_r <= MODE_CHASE;
            dir    <= DIR_UP;
        end else begin
            case (state)
                IDLE: begin
                    LED  <= 5'b00000;
                    TICK <= 1'b0;
                    pre  <= '0;
                    if (EN) begin
                        state  <= RUN;
                        mode_r <= MODE;
                        dir    <= DIR_UP;
                        LED    <= initial_pattern(MODE);
                    end
                end
                RUN: begin
                    if (!EN) begin
                        state <= IDLE;
                        LED   <= 5'b00000;
                        TICK  <= 1'b0;
                        pre   <= '0;
                    end else begin
                        pre  <= pre + WIDTH'(1);
                        TICK <= step_edge;
                        if (step_edge) begin
                            if (MODE != mode_r) begin
                                mode_r <= MODE;
                                LED    <= initial_pattern(MODE);
                                dir    <= DIR_UP;
                            end else begin
                                LED <= next_led;
                                dir <= next_dir;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scheduler.sv
// Directed bench for led_scheduler with an 8-cycle step period.
module tb_led_scheduler;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic [1:0] MODE;
    logic [4:0] LED;
    logic       TICK;
    logic       STATE;

    int checks;
    int failures;

    led_scheduler #(.WIDTH(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .MODE  (MODE),
        .LED   (LED),
        .TICK  (TICK),
        .STATE (STATE)
    );

    // Free-running 10-unit clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle so outputs are sampled off the edge
    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    // Compare one observed value with its expected value
    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    // Check all three outputs together
    task automatic check_all(input string tag, input logic [4:0] led_exp, input logic tick_exp, input logic state_exp);
        check_output({tag, "_led"}, {3'b000, LED}, {3'b000, led_exp});
        check_output({tag, "_tick"}, {7'b0, TICK}, {7'b0, tick_exp});
        check_output({tag, "_state"}, {7'b0, STATE}, {7'b0, state_exp});
    endtask

    // Edges inside a step interval: LED holds, no tick, still running
    task automatic quiet(input int n, input logic [4:0] led_hold, input string tag);
        for (int i = 0; i < n; i++) begin
            edge_step();
            check_all(tag, led_hold, 1'b0, 1'b1);
        end
    endtask

    // The step edge itself: tick pulses and LED takes its new value
    task automatic step_edge_check(input logic [4:0] led_exp, input string tag);
        edge_step();
        check_all(tag, led_exp, 1'b1, 1'b1);
    endtask

    // A full interval of seven quiet edges followed by the step edge
    task automatic full_step(input logic [4:0] led_prev, input logic [4:0] led_exp, input string tag);
        quiet(7, led_prev, tag);
        step_edge_check(led_exp, tag);
    endtask

    // Set the block inputs between edges
    task automatic apply_stimulus(input logic rst, input logic en, input logic [1:0] mode);
        RESET = rst;
        EN    = en;
        MODE  = mode;
    endtask

    logic [4:0] chase_seq [5];
    logic [4:0] bounce_seq [10];
    logic [4:0] prev;
    logic [4:0] cnt;

    initial begin
        checks   = 0;
        failures = 0;
        chase_seq  = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        bounce_seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                       5'b00100, 5'b00010, 5'b00001, 5'b00010, 5'b00100};

        // Reset for two cycles, then idle with EN low
        apply_stimulus(1'b1, 1'b0, 2'd0);
        #1;
        edge_step();
        edge_step();
        check_all("reset", 5'b00000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            edge_step();
            check_all("idle", 5'b00000, 1'b0, 1'b0);
        end

        // Chase from entry
        apply_stimulus(1'b0, 1'b1, 2'd0);
        edge_step();
        check_all("chase_entry", 5'b00001, 1'b0, 1'b1);
        prev = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            full_step(prev, chase_seq[i], "chase");
            prev = chase_seq[i];
        end

        // Switch to bounce: next step reloads 00001, then ten bounce steps
        apply_stimulus(1'b0, 1'b1, 2'd1);
        full_step(prev, 5'b00001, "bounce_switch");
        prev = 5'b00001;
        for (int i = 0; i < 10; i++) begin
            full_step(prev, bounce_seq[i], "bounce");
            prev = bounce_seq[i];
        end

        // Drop to idle, then enter binary directly
        apply_stimulus(1'b0, 1'b0, 2'd2);
        edge_step();
        check_all("binary_idle", 5'b00000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'd2);
        edge_step();
        check_all("binary_entry", 5'b00000, 1'b0, 1'b1);
        prev = 5'b00000;
        cnt  = 5'b00000;
        for (int i = 0; i < 33; i++) begin
            cnt = cnt + 5'd1;
            full_step(prev, cnt, "binary");
            prev = cnt;
        end
        check_output("binary_wrap_end", {3'b000, LED}, 8'b00000001);

        // Blink: switch reloads 11111, then alternates
        apply_stimulus(1'b0, 1'b1, 2'd3);
        full_step(prev, 5'b11111, "blink_switch");
        full_step(5'b11111, 5'b00000, "blink");
        full_step(5'b00000, 5'b11111, "blink");
        full_step(5'b11111, 5'b00000, "blink");

        // Mid-interval mode change only takes effect at the step
        apply_stimulus(1'b0, 1'b0, 2'd0);
        edge_step();
        check_all("midchg_idle", 5'b00000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'd0);
        edge_step();
        check_all("midchg_entry", 5'b00001, 1'b0, 1'b1);
        quiet(3, 5'b00001, "midchg_pre");
        MODE = 2'd2;
        quiet(4, 5'b00001, "midchg_hold");
        step_edge_check(5'b00000, "midchg_step");

        // A glitch that reverts before the step is ignored
        quiet(3, 5'b00000, "glitch_a");
        MODE = 2'd0;
        quiet(2, 5'b00000, "glitch_b");
        MODE = 2'd2;
        quiet(2, 5'b00000, "glitch_c");
        step_edge_check(5'b00001, "glitch_step");

        // EN low on a step edge wins over the step
        quiet(7, 5'b00001, "en_drop_pre");
        EN = 1'b0;
        edge_step();
        check_all("en_drop_step", 5'b00000, 1'b0, 1'b0);
        EN = 1'b1;
        edge_step();
        check_all("reentry", 5'b00000, 1'b0, 1'b1);
        full_step(5'b00000, 5'b00001, "reentry_step");

        // Reset on a step edge wins over the step and EN
        quiet(7, 5'b00001, "rst_pre");
        RESET = 1'b1;
        edge_step();
        check_all("rst_step", 5'b00000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd0);
        edge_step();
        check_all("rst_hold_idle", 5'b00000, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'd0);
        edge_step();
        check_all("rst_reentry", 5'b00001, 1'b0, 1'b1);
        full_step(5'b00001, 5'b00010, "rst_reentry_step");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
